// File: rtl/cpu_pkg.sv
// cpu_pkg: opcode/funct constants, ALU control codes, decode-stage state and control bundle.
package cpu_pkg;
  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J = 6'h02, OP_BEQ = 6'h04, OP_BNE = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08, OP_ANDI = 6'h0C, OP_ORI = 6'h0D, OP_LW = 6'h23, OP_SW = 6'h2B;
  localparam logic [5:0] FN_SLL = 6'h00, FN_ADD = 6'h20, FN_SUB = 6'h22, FN_AND = 6'h24, FN_OR = 6'h25, FN_SLT = 6'h2A;
  typedef enum logic [3:0] {
    ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR = 4'd3, ALU_SLT = 4'd4, ALU_SLL = 4'd5
  } alu_ctrl_t;
  typedef enum logic [1:0] {EMPTY = 2'd0, FULL = 2'd1, BUBBLE = 2'd2} id_state_t;
  typedef struct packed {
    logic      reg_dst;
    logic      alu_src;
    logic      mem_read;
    logic      mem_write;
    logic      mem_to_reg;
    logic      reg_write;
    logic      branch;
    logic      bne;
    logic      jump;
    logic      ext_op;
    alu_ctrl_t alu_ctrl;
  } ctrl_t;
endpackage

// File: rtl/id_stage_if.sv
// id_stage_if: fetch-side, execute-side and decoded-output signals of the decode stage.
interface id_stage_if;
  logic        if_valid, id_ready, ex_ready, flush, ex_memRead, id_valid;
  logic [31:0] if_instr, if_pc4, id_pc4;
  logic [4:0]  ex_rt, rs, rt, rd, shamt;
  logic [15:0] imm16;
  logic        extOp, regDst, aluSrc, memRead, memWrite, memToReg, regWrite, branch, bne, jump, illegal;
  logic [3:0]  aluCtrl;
  modport slave (
    input  if_valid, if_instr, if_pc4, ex_ready, flush, ex_memRead, ex_rt,
    output id_ready, id_valid, id_pc4, rs, rt, rd, shamt, imm16, extOp,
    output regDst, aluSrc, memRead, memWrite, memToReg, regWrite, branch, bne, jump, aluCtrl, illegal
  );
  modport master (
    output if_valid, if_instr, if_pc4, ex_ready, flush, ex_memRead, ex_rt,
    input  id_ready, id_valid, id_pc4, rs, rt, rd, shamt, imm16, extOp,
    input  regDst, aluSrc, memRead, memWrite, memToReg, regWrite, branch, bne, jump, aluCtrl, illegal
  );
endinterface

// File: rtl/id_decoder.sv
// id_decoder: combinational opcode/funct to control-bundle decode with illegal-instruction flag.
module id_decoder
  import cpu_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output ctrl_t      ctrl,
  output logic       illegal
);
  always_comb begin
    ctrl = '0;
    illegal = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        ctrl.reg_dst = 1'b1;
        ctrl.reg_write = 1'b1;
        case (funct)
          FN_ADD: ctrl.alu_ctrl = ALU_ADD;
          FN_SUB: ctrl.alu_ctrl = ALU_SUB;
          FN_AND: ctrl.alu_ctrl = ALU_AND;
          FN_OR: ctrl.alu_ctrl = ALU_OR;
          FN_SLT: ctrl.alu_ctrl = ALU_SLT;
          FN_SLL: ctrl.alu_ctrl = ALU_SLL;
          default: begin
            ctrl = '0;
            illegal = 1'b1;
          end
        endcase
      end
      OP_ADDI: ctrl = '{alu_src: 1'b1, reg_write: 1'b1, ext_op: 1'b1, alu_ctrl: ALU_ADD, default: 1'b0};
      OP_ANDI: ctrl = '{alu_src: 1'b1, reg_write: 1'b1, alu_ctrl: ALU_AND, default: 1'b0};
      OP_ORI: ctrl = '{alu_src: 1'b1, reg_write: 1'b1, alu_ctrl: ALU_OR, default: 1'b0};
      OP_LW: ctrl = '{alu_src: 1'b1, mem_read: 1'b1, mem_to_reg: 1'b1, reg_write: 1'b1, ext_op: 1'b1, alu_ctrl: ALU_ADD, default: 1'b0};
      OP_SW: ctrl = '{alu_src: 1'b1, mem_write: 1'b1, ext_op: 1'b1, alu_ctrl: ALU_ADD, default: 1'b0};
      OP_BEQ: ctrl = '{branch: 1'b1, ext_op: 1'b1, alu_ctrl: ALU_SUB, default: 1'b0};
      OP_BNE: ctrl = '{branch: 1'b1, bne: 1'b1, ext_op: 1'b1, alu_ctrl: ALU_SUB, default: 1'b0};
      OP_J: ctrl = '{jump: 1'b1, alu_ctrl: ALU_ADD, default: 1'b0};
      default: illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/id_stage.sv
// id_stage: IF/ID register, valid/ready handshake FSM and decode; LOAD_USE_STALL_EN adds a load-use bubble.
module id_stage
  import cpu_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input logic       clk,
  input logic       rst_n,
  id_stage_if.slave io
);
  logic [31:0] instr_q, pc4_q;
  logic        valid_q, hazard, live, load, xfer;
  id_state_t   state_q, state_d;
  ctrl_t       ctrl, oc;
  logic        dec_illegal;

  id_decoder u_dec (.opcode(instr_q[31:26]), .funct(instr_q[5:0]), .ctrl(ctrl), .illegal(dec_illegal));

`ifdef LOAD_USE_STALL_EN
  // sw reads rt as store data even though its ALU operand is the immediate
  assign hazard = valid_q && state_q == FULL && io.ex_memRead && io.ex_rt != 5'd0 &&
                  (io.ex_rt == instr_q[25:21] ||
                   (io.ex_rt == instr_q[20:16] && (!ctrl.alu_src || instr_q[31:26] == OP_SW)));
`else
  logic unused_hazard_in;
  assign unused_hazard_in = ^{io.ex_memRead, io.ex_rt};
  assign hazard = 1'b0;
`endif

  assign live = valid_q && state_q == FULL && !hazard;
  assign io.id_ready = !valid_q || (io.ex_ready && !hazard && state_q != BUBBLE);
  assign load = io.if_valid && io.id_ready;
  assign xfer = live && io.ex_ready;

  always_comb begin
    state_d = io.flush ? EMPTY :
              state_q == BUBBLE ? FULL :
              hazard ? BUBBLE :
              load ? FULL :
              xfer ? EMPTY : state_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR;
      pc4_q <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= state_d != EMPTY;
      if (io.flush) instr_q <= NOP_INSTR;
      else if (load) begin
        instr_q <= io.if_instr;
        pc4_q <= io.if_pc4;
      end
    end
  end

  assign oc = live ? ctrl : '0;
  assign io.id_valid = live;
  assign io.id_pc4 = pc4_q;
  assign io.rs = instr_q[25:21];
  assign io.rt = instr_q[20:16];
  assign io.rd = instr_q[15:11];
  assign io.shamt = instr_q[10:6];
  assign io.imm16 = instr_q[15:0];
  assign io.extOp = oc.ext_op;
  assign io.regDst = oc.reg_dst;
  assign io.aluSrc = oc.alu_src;
  assign io.memRead = oc.mem_read;
  assign io.memWrite = oc.mem_write;
  assign io.memToReg = oc.mem_to_reg;
  assign io.regWrite = oc.reg_write;
  assign io.branch = oc.branch;
  assign io.bne = oc.bne;
  assign io.jump = oc.jump;
  assign io.aluCtrl = oc.alu_ctrl;
  assign io.illegal = live && dec_illegal;
endmodule
